// File: rtl/data_mem_arbiter_if.sv
// Data-memory port bundle: the arbiter drives the request side (master),
// the memory answers with read data and a completion strobe (slave).
interface data_mem_arbiter_if;
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        ready;

    modport master (output req, we, be, addr, wd, input rd, ready);
    modport slave  (input req, we, be, addr, wd, output rd, ready);
endinterface

// File: rtl/data_mem_arbiter.sv
// Shares one data-memory port between the core load/store unit and an external
// master: round-robin arbitration, core stall, byte-lane alignment and load extension.
module data_mem_arbiter #(
    parameter bit EXT_FIXED_PRIO = 1'b0
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       core_req_i,
    input  logic                       core_we_i,
    input  logic [2:0]                 core_size_i,
    input  logic [31:0]                core_addr_i,
    input  logic [31:0]                core_wd_i,
    output logic [31:0]                core_rd_o,
    output logic                       core_stall_o,
    input  logic                       ext_req_i,
    input  logic                       ext_we_i,
    input  logic [3:0]                 ext_be_i,
    input  logic [31:0]                ext_addr_i,
    input  logic [31:0]                ext_wd_i,
    output logic                       ext_gnt_o,
    output logic                       ext_rvalid_o,
    output logic [31:0]                ext_rd_o,
    data_mem_arbiter_if.master         mem
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_CORE_BUSY = 2'd1,
        ST_EXT_BUSY  = 2'd2
    } state_e;

    state_e      state_r, state_s;
    logic        core_done_r, last_ext_r, ext_rvalid_r;
    logic        grant_core_s, grant_ext_s, core_elig_s, mem_done_s;
    logic        mem_req_r, mem_we_r;
    logic [3:0]  mem_be_r;
    logic [31:0] mem_addr_r, mem_wd_r, core_rd_r, ext_rd_r;
    logic [2:0]  size_r;
    logic [1:0]  off_r;

    function automatic logic [3:0] store_be(input logic we, input logic [2:0] size, input logic [1:0] off);
        if (!we) begin
            store_be = 4'b1111;
        end else begin
            case (size)
                3'd0, 3'd4: store_be = 4'b0001 << off;
                3'd1, 3'd5: store_be = off[1] ? 4'b1100 : 4'b0011;
                default:    store_be = 4'b1111;
            endcase
        end
    endfunction

    function automatic logic [31:0] store_wd(input logic [2:0] size, input logic [31:0] wd);
        case (size)
            3'd0, 3'd4: store_wd = {4{wd[7:0]}};
            3'd1, 3'd5: store_wd = {2{wd[15:0]}};
            default:    store_wd = wd;
        endcase
    endfunction

    function automatic logic [31:0] load_fmt(input logic [2:0] size, input logic [1:0] off, input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = rd[7:0];
            2'd1:    b = rd[15:8];
            2'd2:    b = rd[23:16];
            default: b = rd[31:24];
        endcase
        h = off[1] ? rd[31:16] : rd[15:0];
        case (size)
            3'd0:    load_fmt = {{24{b[7]}}, b};
            3'd1:    load_fmt = {{16{h[15]}}, h};
            3'd4:    load_fmt = {24'd0, b};
            3'd5:    load_fmt = {16'd0, h};
            default: load_fmt = rd;
        endcase
    endfunction

    // mem_req_r is high exactly while BUSY, so it also qualifies the ready strobe
    assign core_elig_s = core_req_i & ~core_done_r;
    assign mem_done_s  = mem_req_r & mem.ready;

    // Next-state and grant decision
    always_comb begin
        state_s      = state_r;
        grant_core_s = 1'b0;
        grant_ext_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (core_elig_s && ext_req_i) begin
                    if (EXT_FIXED_PRIO || !last_ext_r) begin
                        grant_ext_s = 1'b1;
                        state_s     = ST_EXT_BUSY;
                    end else begin
                        grant_core_s = 1'b1;
                        state_s      = ST_CORE_BUSY;
                    end
                end else if (core_elig_s) begin
                    grant_core_s = 1'b1;
                    state_s      = ST_CORE_BUSY;
                end else if (ext_req_i) begin
                    grant_ext_s = 1'b1;
                    state_s     = ST_EXT_BUSY;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CORE_BUSY, ST_EXT_BUSY: begin
                if (mem_done_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = state_r;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Request latching, completion capture and last-grant tracking
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mem_req_r    <= 1'b0;
            mem_we_r     <= 1'b0;
            mem_be_r     <= 4'd0;
            mem_addr_r   <= 32'd0;
            mem_wd_r     <= 32'd0;
            size_r       <= 3'd0;
            off_r        <= 2'd0;
            last_ext_r   <= 1'b1;
            core_done_r  <= 1'b0;
            ext_rvalid_r <= 1'b0;
            core_rd_r    <= 32'd0;
            ext_rd_r     <= 32'd0;
        end else begin
            core_done_r  <= mem_done_s && (state_r == ST_CORE_BUSY);
            ext_rvalid_r <= mem_done_s && (state_r == ST_EXT_BUSY);
            if (grant_core_s) begin
                mem_req_r  <= 1'b1;
                mem_we_r   <= core_we_i;
                mem_be_r   <= store_be(core_we_i, core_size_i, core_addr_i[1:0]);
                mem_addr_r <= {core_addr_i[31:2], 2'b00};
                mem_wd_r   <= store_wd(core_size_i, core_wd_i);
                size_r     <= core_size_i;
                off_r      <= core_addr_i[1:0];
                last_ext_r <= 1'b0;
            end else if (grant_ext_s) begin
                mem_req_r  <= 1'b1;
                mem_we_r   <= ext_we_i;
                mem_be_r   <= ext_be_i;
                mem_addr_r <= {ext_addr_i[31:2], 2'b00};
                mem_wd_r   <= ext_wd_i;
                last_ext_r <= 1'b1;
            end else if (mem_done_s) begin
                mem_req_r <= 1'b0;
                if (state_r == ST_CORE_BUSY) begin
                    core_rd_r <= load_fmt(size_r, off_r, mem.rd);
                end else begin
                    ext_rd_r <= mem.rd;
                end
            end else begin
                mem_req_r <= mem_req_r;
            end
        end
    end

    // Stall and grant are combinational by design; forced low while in reset
    assign core_stall_o = core_elig_s & rst_i;
    assign ext_gnt_o    = grant_ext_s & rst_i;
    assign ext_rvalid_o = ext_rvalid_r;
    assign ext_rd_o     = ext_rd_r;
    assign core_rd_o    = core_rd_r;
    assign mem.req      = mem_req_r;
    assign mem.we       = mem_we_r;
    assign mem.be       = mem_be_r;
    assign mem.addr     = mem_addr_r;
    assign mem.wd       = mem_wd_r;

endmodule
